// File: rtl/unload_output_file.sv
// unload_output_file: streams a bit-addressed memory out as bytes.
// Bits 8k..8k+7 are read in order and packed LSB-first into byte k. Each
// byte is offered to a downstream transmitter with a one-cycle trigger, and
// the block waits for tx_done before fetching the next byte.
// Optional feature: define UNLOAD_CHECKSUM_EN to append one XOR checksum byte.
module unload_output_file #(
  parameter int NUM_BITS = 784,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              q,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              trigger,
  output logic              busy,
  output logic              done
);

  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int K_W       = $clog2(NUM_BYTES + 1);
  localparam logic [K_W-1:0] LAST_K = K_W'(NUM_BYTES - 1);
`ifdef UNLOAD_CHECKSUM_EN
  localparam logic [K_W-1:0] CSUM_K = K_W'(NUM_BYTES);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [7:0]        data_r, data_s;
  logic [7:0]        sr_r, sr_s;       // incoming bits, newest at bit 7
  logic [2:0]        j_r, j_s;         // index of the bit being captured
  logic [K_W-1:0]    k_r, k_s;         // byte index
  logic              prime_r, prime_s; // first FETCH cycle: read issued, no data yet
  logic              trigger_r, trigger_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
`ifdef UNLOAD_CHECKSUM_EN
  logic [7:0]        csum_r, csum_s;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    csum_fold = acc ^ b;
  endfunction
`endif

  // State register and datapath registers, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      data_r    <= 8'h00;
      sr_r      <= 8'h00;
      j_r       <= 3'd0;
      k_r       <= {K_W{1'b0}};
      prime_r   <= 1'b0;
      trigger_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
      csum_r    <= 8'h00;
`endif
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      sr_r      <= sr_s;
      j_r       <= j_s;
      k_r       <= k_s;
      prime_r   <= prime_s;
      trigger_r <= trigger_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
`ifdef UNLOAD_CHECKSUM_EN
      csum_r    <= csum_s;
`endif
    end
  end

  // Next-state, address sequencing, bit packing and registered output values.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    data_s  = data_r;
    sr_s    = sr_r;
    j_s     = j_r;
    k_s     = k_r;
    prime_s = prime_r;
`ifdef UNLOAD_CHECKSUM_EN
    csum_s  = csum_r;
`endif
    case (state_r)
      S_IDLE: begin
        addr_s = {ADDR_W{1'b0}};
        if (start) begin
          state_s = S_FETCH;
          j_s     = 3'd0;
          k_s     = {K_W{1'b0}};
          prime_s = 1'b1;
`ifdef UNLOAD_CHECKSUM_EN
          csum_s  = 8'h00;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (prime_r) begin
          prime_s = 1'b0;
          addr_s  = addr_r + ADDR_W'(1);
        end else begin
          // q belongs to the address driven one cycle earlier.
          sr_s = {q, sr_r[7:1]};
          j_s  = j_r + 3'd1;
          if (j_r == 3'd7) begin
            state_s = S_SEND;
            data_s  = {q, sr_r[7:1]};
`ifdef UNLOAD_CHECKSUM_EN
            csum_s  = csum_fold(csum_r, {q, sr_r[7:1]});
`endif
          end else if (j_r < 3'd6) begin
            addr_s = addr_r + ADDR_W'(1);
          end else begin
            // Last address of the byte stays put; it advances on tx_done.
            addr_s = addr_r;
          end
        end
      end
      S_SEND: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          k_s = k_r + K_W'(1);
`ifdef UNLOAD_CHECKSUM_EN
          if (k_r == CSUM_K) begin
            state_s = S_FIN;
            addr_s  = {ADDR_W{1'b0}};
          end else if (k_r == LAST_K) begin
            state_s = S_SEND;
            data_s  = csum_r;
            addr_s  = {ADDR_W{1'b0}};
          end else begin
            state_s = S_FETCH;
            prime_s = 1'b1;
            addr_s  = addr_r + ADDR_W'(1);
          end
`else
          if (k_r == LAST_K) begin
            state_s = S_FIN;
            addr_s  = {ADDR_W{1'b0}};
          end else begin
            state_s = S_FETCH;
            prime_s = 1'b1;
            addr_s  = addr_r + ADDR_W'(1);
          end
`endif
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
        addr_s  = {ADDR_W{1'b0}};
      end
      default: begin
        state_s = S_IDLE;
        addr_s  = {ADDR_W{1'b0}};
      end
    endcase
    trigger_s = (state_s == S_SEND);
    busy_s    = (state_s == S_FETCH) || (state_s == S_SEND) || (state_s == S_WAIT);
    done_s    = (state_s == S_FIN);
  end

  assign addr    = addr_r;
  assign data    = data_r;
  assign trigger = trigger_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_unload_output_file.sv
// Bench for unload_output_file: synchronous memory model, transmitter model
// with programmable tx_done delay, and a byte-level reference computed
// directly from memory contents.
module tb_unload_output_file;

  localparam int NUM_BITS = 784;
  localparam int NB       = NUM_BITS / 8;
`ifdef UNLOAD_CHECKSUM_EN
  localparam int NEXP = NB + 1;
`else
  localparam int NEXP = NB;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       q = 1'b0;
  logic       tx_done;
  logic [9:0] addr;
  logic [7:0] data;
  logic       trigger, busy, done;

  logic start_i = 1'b0, start_x = 1'b0;
  logic tx_i = 1'b0, tx_x = 1'b0, tx_auto = 1'b0;
  assign start   = start_i | start_x;
  assign tx_done = tx_i | tx_x | tx_auto;

  unload_output_file #(.NUM_BITS(NUM_BITS), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .tx_done(tx_done),
    .addr(addr), .data(data), .trigger(trigger), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  bit   mem [0:1023];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int   trig_cyc[$];
  int   cd = 0, tx_delay = 20, last_txd_cyc = 0, done_cnt = 0, done_cyc = 0;
  int   start_cyc = 0, prev_addr = 0, inc_cnt = 0, ret_cnt = 0, bad_addr = 0;
  bit   dup_txd = 1'b0, disturb = 1'b0;

  // Synchronous-read memory: q reflects the address of the previous cycle.
  always @(posedge clk) q <= mem[addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs and play the transmitter / disturbance roles.
  always @(negedge clk) begin
    tx_auto = 1'b0;
    tx_x    = 1'b0;
    start_x = 1'b0;
    if (rst) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          tx_auto = 1'b1;
          last_txd_cyc = cyc;
        end
      end
      if (trigger) begin
        got.push_back(data);
        trig_cyc.push_back(cyc);
        cd = tx_delay;
        if (dup_txd) tx_auto = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (disturb && busy && got.size() < NB) begin
        if (cyc == last_txd_cyc + 3) begin
          tx_x    = 1'b1;
          start_x = 1'b1;
        end
        if (cd == 5) start_x = 1'b1;
      end
      if (int'(addr) != prev_addr) begin
        if (int'(addr) == prev_addr + 1) inc_cnt++;
        else if (addr == 10'd0) ret_cnt++;
        else bad_addr++;
        if (int'(addr) > NUM_BITS - 1) bad_addr++;
        prev_addr = int'(addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: byte b is bits 8b..8b+7, LSB first; optional XOR trailer.
  task automatic build_exp();
    logic [7:0] b, x;
    exp_q.delete();
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) if (mem[8 * k + i]) b = b | (8'h01 << i);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef UNLOAD_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic run_unload(input bit hold);
    int bad;
    build_exp();
    got.delete();
    trig_cyc.delete();
    done_cnt  = 0;
    inc_cnt   = 0;
    ret_cnt   = 0;
    bad_addr  = 0;
    prev_addr = int'(addr);
    start_cyc = cyc;
    last_txd_cyc = cyc;
    start_i = 1'b1;
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    for (int n = 0; n < 30000 && done_cnt == 0; n++) @(negedge clk);
    check("done_seen", done_cnt > 0, 1);
    check("byte_count", got.size(), NEXP);
    for (int i = 0; i < NEXP && i < got.size(); i++)
      check($sformatf("byte%0d", i), got[i], exp_q[i]);
    check("done_latency", done_cyc - last_txd_cyc, 1);
    bad = 0;
    for (int i = 1; i < got.size() && i < NB; i++)
      if (trig_cyc[i] - trig_cyc[i-1] != tx_delay + 10) bad++;
    check("byte_spacing", bad, 0);
    check("addr_steps", inc_cnt, NUM_BITS - 1);
    check("addr_return", ret_cnt, 1);
    check("addr_bad", bad_addr, 0);
    if (!hold) begin
      @(negedge clk);
      check("idle_after_done", {29'd0, busy, trigger, done}, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_trigger", trigger, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // tx_done while idle must not wake the block.
    got.delete();
    repeat (3) begin
      tx_i = 1'b1; @(negedge clk);
      tx_i = 1'b0; @(negedge clk);
    end
    check("idle_no_trigger", got.size(), 0);
    check("idle_busy", busy, 0);

    // All ones, 20-cycle transmitter.
    for (int a = 0; a < NUM_BITS; a++) mem[a] = 1'b1;
    tx_delay = 20;
    run_unload(1'b0);
    if (got.size() > 0) check("ones_byte0", got[0], 8'hFF);

    // a mod 3 pattern, latency to first trigger.
    for (int a = 0; a < NUM_BITS; a++) mem[a] = (a % 3 == 0);
    run_unload(1'b0);
    if (trig_cyc.size() > 0) check("first_trigger_edges", trig_cyc[0] - start_cyc, 10);
    if (got.size() > 2) begin
      check("mod3_b0", got[0], 8'h49);
      check("mod3_b1", got[1], 8'h92);
      check("mod3_b2", got[2], 8'h24);
    end

    // Random data with start/tx_done noise and tx_done coincident with trigger.
    for (int a = 0; a < NUM_BITS; a++) mem[a] = 1'($urandom);
    tx_delay = $urandom_range(8, 25);
    disturb = 1'b1;
    dup_txd = 1'b1;
    run_unload(1'b0);
    disturb = 1'b0;
    dup_txd = 1'b0;

    // Reset while waiting on byte 40, then a clean restart.
    for (int a = 0; a < NUM_BITS; a++) mem[a] = (a % 3 == 0);
    tx_delay = 20;
    got.delete();
    done_cnt = 0;
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    for (int n = 0; n < 20000 && got.size() < 41; n++) @(negedge clk);
    check("reached_byte40", got.size(), 41);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {11'd0, addr, data, trigger, busy, done}, 0);
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    tx_delay = $urandom_range(1, 25);
    run_unload(1'b0);

    // start held through FIN restarts from IDLE.
    for (int a = 0; a < NUM_BITS; a++) mem[a] = 1'($urandom);
    tx_delay = $urandom_range(1, 25);
    run_unload(1'b1);
    for (int n = 0; n < 4 && cyc < done_cyc + 2; n++) @(negedge clk);
    check("held_start_restart", busy, 1);
    start_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("final_idle", {29'd0, busy, trigger, done}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
